traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of cycle_cnt.
REQ-002 SHALL have parameter DWELL_W, default 8: width of dwell.
REQ-003 SHALL have parameter MAX_DWELL, default 1: largest legal dwell in one phase, in cycles.
REQ-004 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have light  input  3  observed lamp code:
- red = 3'b100
- green = 3'b010
- yellow = 3'b001
REQ-007 SHALL have err_clr  input  1  clears all sticky error flags.
REQ-008 SHALL have phase  output  2  decoded phase: 0 red, 1 green, 2 yellow, 3 unknown/invalid.
REQ-009 SHALL have valid  output  1  1 while the monitor is locked to a legal phase.
REQ-010 SHALL have dwell  output  DWELL_W  consecutive cycles spent in the current phase.
REQ-011 SHALL have cycle_cnt  output  CNT_W  number of completed red->green->yellow->red cycles.
REQ-012 SHALL have err_code  output  1  sticky flag: an illegal code was seen.
REQ-013 SHALL have err_seq  output  1  sticky flag: an illegal phase transition was seen.
REQ-014 SHALL have err_dwell  output  1  sticky flag: dwell exceeded MAX_DWELL.

Function
REQ-015 SHALL register all outputs; light sampled at edge N is reflected in the outputs after edge N (latency 1 cycle).
REQ-016 SHALL treat any light value other than 100, 010 or 001 as illegal (this includes 000 and multi-hot codes).
REQ-017 SHALL implement a state machine with two states, IDLE (unlocked) and TRACK (locked).
REQ-018 SHALL handle a legal code in IDLE as follows:
- go to TRACK
- phase <= decoded value, valid <= 1, dwell <= 1
- perform no transition check
REQ-019 SHALL treat these transitions as legal in TRACK: red->green, green->yellow, yellow->red.
REQ-020 SHALL handle a legal transition in TRACK as: phase <= new value, dwell <= 1.
REQ-021 SHALL handle the same legal code repeated in TRACK as: phase unchanged, dwell increments, saturating at all-ones.
REQ-022 SHALL handle an illegal transition in TRACK (red->yellow, green->red, yellow->green) as follows:
- err_seq <= 1
- resync: phase <= new value, dwell <= 1, stay in TRACK
- cycle_cnt unchanged
REQ-023 SHALL increment cycle_cnt by 1 only on a legal yellow->red transition in TRACK, wrapping modulo 2^CNT_W.
REQ-024 SHALL handle an illegal code in either state as follows:
- err_code <= 1
- phase <= 3, valid <= 0, dwell <= 0
- go to IDLE
REQ-025 SHALL set err_dwell on the edge where the updated dwell value becomes MAX_DWELL+1.
REQ-026 SHALL keep err_code, err_seq and err_dwell at 1 until rst or err_clr.
REQ-027 SHALL clear all three flags on an edge where err_clr=1 and no new error is detected.
REQ-028 SHALL give a set priority over err_clr when both occur on the same edge, so the flag reads 1.
REQ-029 SHALL NOT change phase, dwell, cycle_cnt or valid as a result of err_clr.

Reset
REQ-030 SHALL, on an edge with rst=1, force: state IDLE, phase=3, valid=0, dwell=0, cycle_cnt=0, err_code=0, err_seq=0, err_dwell=0.
REQ-031 SHALL give rst priority over all other inputs, including mid-cycle and mid-error.
REQ-032 SHALL start the first post-reset edge with light legal from the IDLE behaviour (REQ-018).

Verification
REQ-033 SHALL cover the clean sequence: rst, then light=100,010,001,100 on successive edges -> phase 0,1,2,0; valid=1 throughout; dwell=1 each cycle; cycle_cnt=1; all errors 0.
REQ-034 SHALL cover the skipped phase: locked on 100, then 001 -> err_seq=1, phase=2, dwell=1, cycle_cnt unchanged; then 100 -> cycle_cnt increments.
REQ-035 SHALL cover the illegal code: locked, then light=011 -> err_code=1, phase=3, valid=0, dwell=0; then 010 -> valid=1, phase=1, err_seq stays 0.
REQ-036 SHALL cover dwell overrun with MAX_DWELL=4: hold 100 for 5 edges -> dwell=5 and err_dwell=1 after the 5th edge; dwell saturates at 255 when DWELL_W=8.
REQ-037 SHALL cover clear vs set: err_seq=1, then err_clr=1 together with green->red -> err_seq=1; the next edge with err_clr=1 and a legal step -> err_seq=0.
REQ-038 SHALL cover counter wrap and mid-run reset:
- CNT_W=2, four full cycles -> cycle_cnt 1,2,3,0
- rst asserted mid-green -> all outputs at reset values on the next edge

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Observes a three-lamp traffic signal, tracks phase and dwell time, counts
// complete red->green->yellow cycles and raises sticky code/sequence/dwell errors.
module traffic_light_monitor #(
    parameter int CNT_W     = 8,
    parameter int DWELL_W   = 8,
    parameter int MAX_DWELL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         light,
    input  logic               err_clr,
    output logic [1:0]         phase,
    output logic               valid,
    output logic [DWELL_W-1:0] dwell,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               err_code,
    output logic               err_seq,
    output logic               err_dwell
);

    typedef enum logic {IDLE, TRACK} state_t;

    localparam logic [1:0] PH_RED    = 2'd0;
    localparam logic [1:0] PH_GREEN  = 2'd1;
    localparam logic [1:0] PH_YELLOW = 2'd2;
    localparam logic [1:0] PH_NONE   = 2'd3;

    // One bit wider than dwell so a limit past all-ones can never match.
    localparam logic [DWELL_W:0] DWELL_LIMIT = (DWELL_W+1)'(MAX_DWELL + 1);

    state_t             state;
    logic               code_ok;
    logic [1:0]         code_ph;
    logic [1:0]         succ_ph;
    logic               tracking;
    logic               same_ph;
    logic               legal_step;
    logic               bad_step;
    logic               wrap_step;
    logic [DWELL_W-1:0] dwell_nxt;
    logic               dwell_over;

    always_comb begin
        code_ok = 1'b1;
        code_ph = PH_NONE;
        case (light)
            3'b100:  code_ph = PH_RED;
            3'b010:  code_ph = PH_GREEN;
            3'b001:  code_ph = PH_YELLOW;
            default: code_ok = 1'b0;
        endcase
    end

    assign succ_ph    = (phase == PH_YELLOW) ? PH_RED : phase + 2'd1;
    assign tracking   = (state == TRACK) && code_ok;
    assign same_ph    = tracking && (code_ph == phase);
    assign legal_step = tracking && (code_ph == succ_ph);
    assign bad_step   = tracking && !same_ph && !legal_step;
    assign wrap_step  = legal_step && (phase == PH_YELLOW);

    always_comb begin
        dwell_nxt = DWELL_W'(1);
        if (!code_ok)
            dwell_nxt = '0;
        else if (same_ph)
            dwell_nxt = (&dwell) ? dwell : dwell + DWELL_W'(1);
    end

    // A saturated counter holding at the limit is not a fresh overrun.
    assign dwell_over = code_ok && ({1'b0, dwell_nxt} == DWELL_LIMIT) &&
                        !(same_ph && (&dwell));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= PH_NONE;
            valid     <= 1'b0;
            dwell     <= '0;
            cycle_cnt <= '0;
            err_code  <= 1'b0;
            err_seq   <= 1'b0;
            err_dwell <= 1'b0;
        end else begin
            err_code  <= !code_ok   || (err_code  && !err_clr);
            err_seq   <= bad_step   || (err_seq   && !err_clr);
            err_dwell <= dwell_over || (err_dwell && !err_clr);
            dwell     <= dwell_nxt;
            if (!code_ok) begin
                state <= IDLE;
                phase <= PH_NONE;
                valid <= 1'b0;
            end else begin
                state <= TRACK;
                phase <= code_ph;
                valid <= 1'b1;
                if (wrap_step)
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: directed lamp vectors push hand-computed expectations,
// a monitor pops one per clock and compares against the registered outputs.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b001;

    typedef struct packed {
        logic [1:0] phase;
        logic       valid;
        logic [7:0] dwell;
        logic [1:0] cnt;
        logic       ec;
        logic       es;
        logic       ed;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] light = 3'b000;
    logic       err_clr = 1'b0;
    logic [1:0] phase;
    logic       valid;
    logic [7:0] dwell;
    logic [1:0] cycle_cnt;
    logic       err_code;
    logic       err_seq;
    logic       err_dwell;

    exp_t  sb_q[$];
    string name_q[$];
    int    assertions = 0;
    int    failures = 0;

    traffic_light_monitor #(.CNT_W(2), .DWELL_W(8), .MAX_DWELL(4)) dut (
        .clk(clk), .rst(rst), .light(light), .err_clr(err_clr),
        .phase(phase), .valid(valid), .dwell(dwell), .cycle_cnt(cycle_cnt),
        .err_code(err_code), .err_seq(err_seq), .err_dwell(err_dwell)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [2:0] l, input logic c,
                                 input logic [1:0] ph, input logic v, input logic [7:0] dw,
                                 input logic [1:0] cc, input logic ec, input logic es,
                                 input logic ed, input string name);
        exp_t e;
        @(negedge clk);
        rst     = r;
        light   = l;
        err_clr = c;
        e = '{phase: ph, valid: v, dwell: dw, cnt: cc, ec: ec, es: es, ed: ed};
        sb_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        exp_t got;
        got = '{phase: phase, valid: valid, dwell: dwell, cnt: cycle_cnt,
                ec: err_code, es: err_seq, ed: err_dwell};
        assertions++;
        if (got !== e) begin
            failures++;
            $display("[TB] FAIL %s: got ph=%0d v=%0b dw=%0d cnt=%0d ec/es/ed=%b%b%b, want ph=%0d v=%0b dw=%0d cnt=%0d ec/es/ed=%b%b%b",
                     name, got.phase, got.valid, got.dwell, got.cnt, got.ec, got.es, got.ed,
                     e.phase, e.valid, e.dwell, e.cnt, e.ec, e.es, e.ed);
        end
    endtask

    // Registered outputs settle after each rising edge; compare one entry per clock.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0)
            checkOutput(sb_q.pop_front(), name_q.pop_front());
    end

    initial begin
        // reset, then a clean cycle
        applyStimulus(1, 3'b000, 0, 3, 0, 0, 0, 0, 0, 0, "reset");
        applyStimulus(0, R, 0, 0, 1, 1, 0, 0, 0, 0, "clean_red");
        applyStimulus(0, G, 0, 1, 1, 1, 0, 0, 0, 0, "clean_green");
        applyStimulus(0, Y, 0, 2, 1, 1, 0, 0, 0, 0, "clean_yellow");
        applyStimulus(0, R, 0, 0, 1, 1, 1, 0, 0, 0, "clean_wrap");
        // skipped phase
        applyStimulus(0, Y, 0, 2, 1, 1, 1, 0, 1, 0, "skip_red_yellow");
        applyStimulus(0, R, 0, 0, 1, 1, 2, 0, 1, 0, "skip_then_red");
        // clear versus set
        applyStimulus(0, G, 0, 1, 1, 1, 2, 0, 1, 0, "seq_sticky");
        applyStimulus(0, R, 1, 0, 1, 1, 2, 0, 1, 0, "clr_vs_set");
        applyStimulus(0, G, 1, 1, 1, 1, 2, 0, 0, 0, "clr_effective");
        applyStimulus(0, Y, 0, 2, 1, 1, 2, 0, 0, 0, "after_clr");
        // illegal codes
        applyStimulus(0, 3'b011, 0, 3, 0, 0, 2, 1, 0, 0, "code_011");
        applyStimulus(0, G, 0, 1, 1, 1, 2, 1, 0, 0, "relock_green");
        applyStimulus(0, G, 1, 1, 1, 2, 2, 0, 0, 0, "clr_code");
        applyStimulus(0, 3'b000, 0, 3, 0, 0, 2, 1, 0, 0, "code_000");
        applyStimulus(0, 3'b111, 0, 3, 0, 0, 2, 1, 0, 0, "code_111");
        applyStimulus(0, R, 1, 0, 1, 1, 2, 0, 0, 0, "relock_red_clr");
        // dwell overrun at MAX_DWELL=4 and saturation
        applyStimulus(0, R, 0, 0, 1, 2, 2, 0, 0, 0, "dwell_2");
        applyStimulus(0, R, 0, 0, 1, 3, 2, 0, 0, 0, "dwell_3");
        applyStimulus(0, R, 0, 0, 1, 4, 2, 0, 0, 0, "dwell_4");
        applyStimulus(0, R, 0, 0, 1, 5, 2, 0, 0, 1, "dwell_over");
        for (int i = 6; i <= 255; i++)
            applyStimulus(0, R, 0, 0, 1, 8'(i), 2, 0, 0, 1, "dwell_climb");
        applyStimulus(0, R, 0, 0, 1, 255, 2, 0, 0, 1, "dwell_sat");
        applyStimulus(0, R, 1, 0, 1, 255, 2, 0, 0, 0, "dwell_sat_clr");
        // counter wrap with CNT_W=2
        applyStimulus(0, G, 0, 1, 1, 1, 2, 0, 0, 0, "wrap_g1");
        applyStimulus(0, Y, 0, 2, 1, 1, 2, 0, 0, 0, "wrap_y1");
        applyStimulus(0, R, 0, 0, 1, 1, 3, 0, 0, 0, "wrap_cnt3");
        applyStimulus(0, G, 0, 1, 1, 1, 3, 0, 0, 0, "wrap_g2");
        applyStimulus(0, Y, 0, 2, 1, 1, 3, 0, 0, 0, "wrap_y2");
        applyStimulus(0, R, 0, 0, 1, 1, 0, 0, 0, 0, "wrap_cnt0");
        applyStimulus(0, G, 0, 1, 1, 1, 0, 0, 0, 0, "wrap_g3");
        applyStimulus(0, Y, 0, 2, 1, 1, 0, 0, 0, 0, "wrap_y3");
        applyStimulus(0, R, 0, 0, 1, 1, 1, 0, 0, 0, "wrap_cnt1");
        // mid-run reset and reset over an error
        applyStimulus(0, G, 0, 1, 1, 1, 1, 0, 0, 0, "pre_rst_g");
        applyStimulus(0, G, 0, 1, 1, 2, 1, 0, 0, 0, "pre_rst_g2");
        applyStimulus(1, G, 0, 3, 0, 0, 0, 0, 0, 0, "rst_mid_green");
        applyStimulus(0, Y, 0, 2, 1, 1, 0, 0, 0, 0, "post_rst_lock");
        applyStimulus(1, 3'b011, 0, 3, 0, 0, 0, 0, 0, 0, "rst_over_bad");
        applyStimulus(0, 3'b011, 0, 3, 0, 0, 0, 1, 0, 0, "bad_after_rst");
        applyStimulus(1, R, 1, 3, 0, 0, 0, 0, 0, 0, "rst_final");

        for (int k = 0; k < 8 && sb_q.size() > 0; k++)
            @(negedge clk);
        if (sb_q.size() != 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
